// File: rtl/row_clear_ctrl.sv
// row_clear_ctrl: row-clear sequencer for a 4-wide, 3-row play-field.
// A grid is accepted in IDLE. Full rows are then found top row first and
// removed one per CLEAR cycle. The rows above each cleared row drop down by one.
// When no full row remains, the block pulses done, reports how many rows were
// cleared, and goes back to IDLE. A saturating score counts every cleared row.
module row_clear_ctrl #(
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [11:0]        load_grid,
    input  logic               score_clr,
    output logic               ready,
    output logic               busy,
    output logic [11:0]        grid,
    output logic               done,
    output logic [1:0]         lines_cleared,
    output logic [SCORE_W-1:0] score
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DETECT = 2'd1;
    localparam logic [1:0] ST_CLEAR  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    // One-hot full-row flags. Only the topmost full row is flagged.
    function automatic logic [2:0] full_row_onehot(input logic [11:0] g);
        logic [2:0] f;
        if (g[3:0] == 4'hF) begin
            f = 3'b001;
        end else if (g[7:4] == 4'hF) begin
            f = 3'b010;
        end else if (g[11:8] == 4'hF) begin
            f = 3'b100;
        end else begin
            f = 3'b000;
        end
        return f;
    endfunction

    // Converts the one-hot flag to a row index. A zero flag never reaches here.
    function automatic logic [1:0] onehot_to_row(input logic [2:0] f);
        logic [1:0] r;
        case (f)
            3'b001:  r = 2'd0;
            3'b010:  r = 2'd1;
            3'b100:  r = 2'd2;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Removes the selected row. The rows above it shift down one place and
    // an empty row enters at the top. Rows below the cleared row do not move.
    function automatic logic [11:0] clear_row(input logic [11:0] g, input logic [1:0] row);
        logic [11:0] n;
        case (row)
            2'd0:    n = {g[11:8], g[7:4], 4'h0};
            2'd1:    n = {g[11:8], g[3:0], 4'h0};
            2'd2:    n = {g[7:4],  g[3:0], 4'h0};
            default: n = g;
        endcase
        return n;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [11:0]        grid_q, grid_d;
    logic [1:0]         row_sel_q, row_sel_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [1:0]         lines_q, lines_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               score_inc_s;
    logic [2:0]         full_s;

    // Combinational detection of full rows on the registered grid.
    always_comb begin
        full_s = full_row_onehot(grid_q);
    end

    // Next-state and datapath logic for the sequencer.
    always_comb begin
        state_d     = state_q;
        grid_d      = grid_q;
        row_sel_d   = row_sel_q;
        cnt_d       = cnt_q;
        lines_d     = lines_q;
        score_inc_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    grid_d  = load_grid;
                    cnt_d   = 2'd0;
                    state_d = ST_DETECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DETECT: begin
                if (full_s == 3'b000) begin
                    state_d = ST_DONE;
                end else begin
                    row_sel_d = onehot_to_row(full_s);
                    state_d   = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                grid_d      = clear_row(grid_q, row_sel_q);
                cnt_d       = cnt_q + 2'd1;
                score_inc_s = 1'b1;
                state_d     = ST_DETECT;
            end
            ST_DONE: begin
                lines_d = cnt_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Score update. A clear request takes priority over a same-cycle
    // increment, and an increment does nothing once the score is saturated.
    always_comb begin
        if (score_clr) begin
            score_d = '0;
        end else if (score_inc_s && (score_q != SCORE_MAX)) begin
            score_d = score_q + {{(SCORE_W-1){1'b0}}, 1'b1};
        end else begin
            score_d = score_q;
        end
    end

    // State and datapath registers, with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grid_q    <= 12'h000;
            row_sel_q <= 2'd0;
            cnt_q     <= 2'd0;
            lines_q   <= 2'd0;
            score_q   <= '0;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            row_sel_q <= row_sel_d;
            cnt_q     <= cnt_d;
            lines_q   <= lines_d;
            score_q   <= score_d;
        end
    end

    // Output decode from registered state. During the done cycle the new
    // count is driven straight through, so consumers can use it with done.
    always_comb begin
        ready = (state_q == ST_IDLE);
        busy  = (state_q == ST_DETECT) || (state_q == ST_CLEAR);
        done  = (state_q == ST_DONE);
        grid  = grid_q;
        score = score_q;
        if (state_q == ST_DONE) begin
            lines_cleared = cnt_q;
        end else begin
            lines_cleared = lines_q;
        end
    end

endmodule

// File: tb/tb_row_clear_ctrl.sv
// Self-checking bench for row_clear_ctrl (SCORE_W=2 so saturation is reachable).
module tb_row_clear_ctrl;

    localparam int SW   = 2;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [11:0]   load_grid;
    logic          score_clr;
    logic          ready;
    logic          busy;
    logic [11:0]   grid;
    logic          done;
    logic [1:0]    lines_cleared;
    logic [SW-1:0] score;

    int n_checks = 0;
    int n_fail   = 0;
    int model_score = 0;

    row_clear_ctrl #(.SCORE_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .load_grid(load_grid),
        .score_clr(score_clr), .ready(ready), .busy(busy), .grid(grid),
        .done(done), .lines_cleared(lines_cleared), .score(score)
    );

    always #5 clk = ~clk;

    // Row-level reference model. Repeatedly removes the topmost full row,
    // places an empty row on top, and counts the rows removed.
    function automatic void model_process(input logic [11:0] g, output logic [11:0] gout, output int k);
        logic [3:0] rows [3];
        int hit;
        for (int r = 0; r < 3; r++) rows[r] = g[r*4 +: 4];
        k = 0;
        for (int it = 0; it < 4; it++) begin
            hit = -1;
            for (int r = 0; r < 3; r++) if (hit < 0 && rows[r] == 4'hF) hit = r;
            if (hit >= 0) begin
                for (int j = hit; j > 0; j--) rows[j] = rows[j-1];
                rows[0] = 4'h0;
                k++;
            end
        end
        gout = {rows[2], rows[1], rows[0]};
    endfunction

    // Waits for ready, loads one grid, then follows it through to done and one cycle beyond.
    task automatic run_grid(input logic [11:0] g, input logic scr, input string tag);
        logic [11:0] exp_g;
        int k, cyc, w;
        model_process(g, exp_g, k);
        w = 0;
        while (ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL %s ready_wait: ready=%b required 1", tag, ready); end
        load = 1'b1; load_grid = g; score_clr = scr;
        @(negedge clk);
        load = 1'b0; score_clr = 1'b0; load_grid = 12'($urandom);
        if (scr) model_score = 0;
        model_score = (model_score + k > SMAX) ? SMAX : model_score + k;
        cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            n_checks++;
            if (busy !== 1'b1 || ready !== 1'b0) begin
                n_fail++; $display("FAIL %s busy c%0d: busy=%b ready=%b required 1/0", tag, cyc, busy, ready);
            end
            @(negedge clk); cyc++;
        end
        n_checks++;
        if (cyc != 2*k + 2) begin n_fail++; $display("FAIL %s latency: done in cycle %0d required %0d", tag, cyc, 2*k+2); end
        n_checks++;
        if (lines_cleared !== 2'(k)) begin n_fail++; $display("FAIL %s lines_at_done: %0d required %0d", tag, lines_cleared, k); end
        n_checks++;
        if (grid !== exp_g) begin n_fail++; $display("FAIL %s grid: %h required %h", tag, grid, exp_g); end
        n_checks++;
        if (score !== SW'(model_score)) begin n_fail++; $display("FAIL %s score: %0d required %0d", tag, score, model_score); end
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0 || lines_cleared !== 2'(k) || grid !== exp_g) begin
            n_fail++;
            $display("FAIL %s after_done: ready=%b done=%b lines=%0d grid=%h required 1 0 %0d %h",
                     tag, ready, done, lines_cleared, grid, k, exp_g);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; load_grid = 12'hABC; score_clr = 1'b0;
        #12;
        n_checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || grid !== 12'h000 ||
            lines_cleared !== 2'd0 || score !== '0) begin
            n_fail++;
            $display("FAIL reset: ready=%b busy=%b done=%b grid=%h lines=%0d score=%0d required 1 0 0 000 0 0",
                     ready, busy, done, grid, lines_cleared, score);
        end
        @(negedge clk); rst_n = 1'b1;
        model_score = 0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_grid(12'h000, 1'b0, "empty");
        run_grid(12'hF07, 1'b0, "bottom_full");
        run_grid(12'hDFF, 1'b0, "two_top");
        run_grid(12'hFFF, 1'b0, "all_full");
    endtask

    task automatic test_saturation();
        run_grid(12'hF00, 1'b1, "sat1");
        run_grid(12'hF00, 1'b0, "sat2");
        run_grid(12'hF00, 1'b0, "sat3");
        run_grid(12'hF00, 1'b0, "sat4");
    endtask

    // Loads FFF, pulses a load while busy, and checks every grid step.
    task automatic test_busy_ignore();
        int cyc;
        load = 1'b1; load_grid = 12'hFFF;
        @(negedge clk);
        load = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            if (cyc == 3) begin load = 1'b1; load_grid = 12'h00F; end
            else begin load = 1'b0; end
            @(negedge clk); cyc++;
            if (cyc == 3 || cyc == 5 || cyc == 7) begin
                n_checks++;
                if (grid !== ((cyc == 3) ? 12'hFF0 : (cyc == 5) ? 12'hF00 : 12'h000)) begin
                    n_fail++; $display("FAIL busy_ignore step c%0d: grid=%h", cyc, grid);
                end
            end
        end
        load = 1'b0;
        model_score = (model_score + 3 > SMAX) ? SMAX : model_score + 3;
        n_checks++;
        if (cyc != 8 || lines_cleared !== 2'd3 || grid !== 12'h000) begin
            n_fail++; $display("FAIL busy_ignore end: cycle=%0d lines=%0d grid=%h required 8 3 000", cyc, lines_cleared, grid);
        end
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1 || grid !== 12'h000) begin
            n_fail++; $display("FAIL busy_ignore idle: ready=%b grid=%h required 1 000", ready, grid);
        end
    endtask

    // score_clr during the CLEAR cycle wins over the increment.
    task automatic test_score_clr_in_clear();
        int cyc;
        load = 1'b1; load_grid = 12'hF00;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        score_clr = 1'b1;
        @(negedge clk);
        score_clr = 1'b0;
        model_score = 0;
        n_checks++;
        if (score !== '0 || grid !== 12'h000) begin
            n_fail++; $display("FAIL clr_in_clear: score=%0d grid=%h required 0 000", score, grid);
        end
        cyc = 3;
        while (done !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        n_checks++;
        if (cyc != 4 || lines_cleared !== 2'd1 || score !== '0) begin
            n_fail++; $display("FAIL clr_in_clear done: cycle=%0d lines=%0d score=%0d required 4 1 0", cyc, lines_cleared, score);
        end
        @(negedge clk);
    endtask

    // Asynchronous reset while CLEAR is in progress.
    task automatic test_async_reset();
        load = 1'b1; load_grid = 12'hFFF;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (grid !== 12'h000 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0 ||
            score !== '0 || lines_cleared !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: grid=%h busy=%b ready=%b done=%b score=%0d lines=%0d",
                     grid, busy, ready, done, score, lines_cleared);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL async_reset no_done: done=%b required 0", done); end
        end
        rst_n = 1'b1;
        model_score = 0;
        @(negedge clk);
        run_grid(12'hF0F, 1'b0, "post_reset");
    endtask

    // Random grids, biased toward full rows, with occasional score clears and idle gaps.
    task automatic test_random();
        logic [11:0] g;
        logic scr;
        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < 3; r++) g[r*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            scr = ($urandom_range(0, 3) == 0);
            run_grid(g, scr, "random");
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_saturation();
        test_score_clr_in_clear();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
